// File: rtl/gray_decode_arbiter.sv
// gray_decode_arbiter: round-robin arbiter that shares one 4-bit Gray-to-binary
// converter among NREQ requesters and returns results on a valid/ready port.
//
// Build option: define GRAY_ARB_FIXED_PRIO_EN for fixed priority, where the
// lowest-index request wins and ptr stays 0. Round-robin is the default.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          per-requester request level (held until granted)
//   gray_bus     Gray word of requester i on bits [4i+3:4i]
//   gnt          one-hot single-cycle pulse when a requester's word is captured
//   busy         high whenever the FSM is not IDLE (decoded from state)
//   out_valid    out_bin/out_id hold a result
//   out_ready    consumer accepts the result
//   out_bin      binary value of the captured Gray word
//   out_id       index of the requester that supplied out_bin
module gray_decode_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] gray_bus,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_bin,
    output logic [IDW-1:0]    out_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id_q;
    logic [3:0]     gray_q;

    logic           win_valid;
    logic [IDW-1:0] win_idx;
    logic [3:0]     bin_c;
    logic [3:0]     gray_words [NREQ];

    // Unpack the flat Gray bus into one word per requester.
    for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
        assign gray_words[g] = gray_bus[4*g +: 4];
    end

    // Winner: first set request scanning upward from ptr, wrapping at NREQ.
    // In the fixed-priority build ptr never leaves 0, so this is lowest-index.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            logic [IDW-1:0] cand;
            cand = IDW'((32'(ptr) + i) % NREQ);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Shared Gray-to-binary converter: each binary bit is the XOR of all
    // Gray bits at or above it.
    assign bin_c = {gray_q[3], ^gray_q[3:2], ^gray_q[3:1], ^gray_q[3:0]};

    assign busy = (state != IDLE);

    // Arbitration / conversion / handshake FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            id_q      <= '0;
            gray_q    <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_id    <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        gray_q       <= gray_words[win_idx];
                        id_q         <= win_idx;
                        gnt[win_idx] <= 1'b1;
                        state        <= CONVERT;
                    end
                end
                CONVERT: begin
                    out_bin   <= bin_c;
                    out_id    <= id_q;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef GRAY_ARB_FIXED_PRIO_EN
                        ptr       <= '0;
`else
                        ptr       <= IDW'((32'(out_id) + 32'd1) % NREQ);
`endif
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Self-checking bench for gray_decode_arbiter (NREQ = 4): directed vector
// table, randomized transactions against a transaction-level model, and
// hand-written reset and idle sequences.
module tb_gray_decode_arbiter;

    localparam int unsigned NREQ = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] gray_bus;
    logic [3:0]  gnt;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_bin;
    logic [1:0]  out_id;

    int n_chk  = 0;
    int n_fail = 0;
    int m_ptr  = 0;

    gray_decode_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gray_bus  (gray_bus),
        .gnt       (gnt),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  r;
        logic [15:0] g;
        int          hold;
        int          exp_id;
        int          exp_bin;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Binary value of a Gray word: XOR of the word with all its right shifts.
    function automatic int model_g2b(input logic [3:0] g);
        return int'(g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3));
    endfunction

    // Winner: walk the requesters in rotated order starting at the pointer.
    function automatic int model_pick(input logic [3:0] r, input int p);
        int q[$];
        int start;
`ifdef GRAY_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = p;
`endif
        for (int k = 0; k < 4; k++) q.push_back((start + k) % 4);
        while (q.size() > 0) begin
            int c;
            c = q.pop_front();
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // One full transaction starting at a falling edge with the FSM idle.
    task automatic txn(input logic [3:0] r, input logic [15:0] g, input int hold,
                       input int exp_id, input int exp_bin, input bit early_ready);
        req       = r;
        gray_bus  = g;
        out_ready = 1'b0;
        @(negedge clk);
        check("gnt", int'(gnt), int'(4'b0001 << exp_id));
        check("busy_conv", int'(busy), 1);
        check("valid_conv", int'(out_valid), 0);
        req       = '0;
        out_ready = early_ready;
        gray_bus  = $urandom;
        @(negedge clk);
        check("valid", int'(out_valid), 1);
        check("out_bin", int'(out_bin), exp_bin);
        check("out_id", int'(out_id), exp_id);
        check("gnt_clear", int'(gnt), 0);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            req = 4'($urandom);
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_bin", int'(out_bin), exp_bin);
            check("hold_id", int'(out_id), exp_id);
            check("hold_gnt", int'(gnt), 0);
            check("hold_busy", int'(busy), 1);
        end
        req       = '0;
        out_ready = 1'b1;
        @(negedge clk);
        check("valid_clr", int'(out_valid), 0);
        check("busy_idle", int'(busy), 0);
        out_ready = 1'b0;
`ifdef GRAY_ARB_FIXED_PRIO_EN
        m_ptr = 0;
`else
        m_ptr = (exp_id + 1) % 4;
`endif
    endtask

    initial begin
        vec_t vecs[$];
        rst_n     = 1'b0;
        req       = '0;
        gray_bus  = '0;
        out_ready = 1'b0;
        #12;
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_bin", int'(out_bin), 0);
        check("rst_id", int'(out_id), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no requests: nothing happens.
        repeat (3) begin
            @(negedge clk);
            check("idle_gnt", int'(gnt), 0);
            check("idle_busy", int'(busy), 0);
        end

`ifndef GRAY_ARB_FIXED_PRIO_EN
        // Round robin 0,1,2,3,0; single conversion; ptr=3 with 1001; backpressure.
        vecs.push_back('{4'b1111, 16'h8310, 0, 0, 0});
        vecs.push_back('{4'b1111, 16'h8310, 1, 1, 1});
        vecs.push_back('{4'b1111, 16'h8310, 0, 2, 2});
        vecs.push_back('{4'b1111, 16'h8310, 2, 3, 15});
        vecs.push_back('{4'b1111, 16'h8310, 0, 0, 0});
        vecs.push_back('{4'b0100, 16'h0D00, 0, 2, 9});
        vecs.push_back('{4'b1001, 16'h6005, 0, 3, 4});
        vecs.push_back('{4'b1001, 16'h6005, 0, 0, 6});
        vecs.push_back('{4'b0010, 16'h00F0, 5, 1, 10});
        for (int i = 0; i < vecs.size(); i++)
            txn(vecs[i].r, vecs[i].g, vecs[i].hold, vecs[i].exp_id, vecs[i].exp_bin, 1'b0);
`else
        // Fixed priority: req[0] and req[1] both asserted, only requester 0 wins.
        for (int i = 0; i < 6; i++)
            txn(4'b0011, 16'h00A5, i % 3, 0, 6, 1'b0);
`endif

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  r;
            logic [15:0] g;
            logic [3:0]  w;
            int          id;
            r  = 4'($urandom_range(1, 15));
            g  = 16'($urandom);
            id = model_pick(r, m_ptr);
            w  = g[4*id +: 4];
            txn(r, g, int'($urandom_range(0, 3)), id, model_g2b(w), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of HOLD drops the result.
        req      = 4'b0100;
        gray_bus = 16'h0D00;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        check("pre_rst_valid", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_gnt", int'(gnt), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_bin", int'(out_bin), 0);
        check("mid_rst_id", int'(out_id), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_valid", int'(out_valid), 0);
            check("post_rst_gnt", int'(gnt), 0);
            check("post_rst_busy", int'(busy), 0);
        end

        // Pointer restarts at 0 after reset.
        txn(4'b1111, 16'h8310, 0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
